// File: rtl/apb_slave_regfile.sv
// APB slave with a 16 x 8-bit register file, programmable wait states and
// address / read-only / data-range error reporting through PSLVERR and err.

package apb_pkg;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        SLAVE_IDLE  = 2'd0,
        SLAVE_WRITE = 2'd1,
        SLAVE_READ  = 2'd2
    } apb_slave_state_t;

    typedef struct packed {
        logic addr_err;
        logic addv_err;
        logic data_err;
    } apb_error_t;
endpackage

module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                    WAIT_STATES = 1,
    parameter int                    MEM_DEPTH   = 12,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 8'hA5,
    parameter logic [DATA_WIDTH-1:0] MAX_WDATA   = 8'hF0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [2:0]            err
);

    localparam int                  NUM_ENTRIES = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [2:0]          WAIT_INIT   = 3'(WAIT_STATES);

    apb_slave_state_t      state_q, state_d;
    logic [2:0]            wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    apb_error_t            pend_q, pend_d;
    apb_error_t            err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] mem_d [NUM_ENTRIES];

    apb_error_t            setup_err;
    logic [DATA_WIDTH-1:0] setup_rdata;

    // Error flags and read data are resolved from the setup-phase inputs.
    always_comb begin
        setup_err          = '0;
        setup_err.addr_err = ({1'b0, paddr} >= DEPTH_LIMIT);
        setup_err.addv_err = pwrite && (paddr == '0);
        setup_err.data_err = pwrite && (pwdata > MAX_WDATA);
        if (paddr == '0) begin
            setup_rdata = ID_VALUE;
        end else if (setup_err.addr_err) begin
            setup_rdata = '0;
        end else begin
            setup_rdata = mem_q[paddr];
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        prdata_d   = prdata_q;
        pend_d     = pend_q;
        err_d      = err_q;
        mem_d      = mem_q;
        case (state_q)
            SLAVE_IDLE: begin
                if (psel && !penable) begin
                    state_d    = pwrite ? SLAVE_WRITE : SLAVE_READ;
                    addr_d     = paddr;
                    wdata_d    = pwdata;
                    wait_cnt_d = WAIT_INIT;
                    pend_d     = setup_err;
                    if (!pwrite) begin
                        prdata_d = setup_rdata;
                    end
                end
            end
            SLAVE_WRITE, SLAVE_READ: begin
                if (!psel) begin
                    state_d = SLAVE_IDLE;
                end else if (penable) begin
                    if (wait_cnt_q != 3'd0) begin
                        wait_cnt_d = wait_cnt_q - 3'd1;
                    end else begin
                        // Completion: only an error-free write touches the array.
                        state_d = SLAVE_IDLE;
                        err_d   = pend_q;
                        if ((state_q == SLAVE_WRITE) && (pend_q == '0)) begin
                            mem_d[addr_q] = wdata_q;
                        end
                    end
                end
            end
            default: state_d = SLAVE_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= SLAVE_IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            prdata_q   <= '0;
            pend_q     <= '0;
            err_q      <= '0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            prdata_q   <= prdata_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            mem_q      <= mem_d;
        end
    end

    assign pready  = (state_q != SLAVE_IDLE) && psel && penable && (wait_cnt_q == 3'd0);
    assign pslverr = pready && (|pend_q);
    assign prdata  = prdata_q;
    assign err     = err_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench: three slaves (W=1, W=0, W=7) on a shared bus with
// separate selects, compared against a transfer-level reference model.

module tb_apb_slave_regfile;

    logic       pclk;
    logic       preset;
    logic [2:0] psel_v;
    logic       penable;
    logic       pwrite;
    logic [3:0] paddr;
    logic [7:0] pwdata;

    logic [2:0][7:0] prdata_v;
    logic [2:0]      pready_v;
    logic [2:0]      pslverr_v;
    logic [2:0][2:0] err_v;

    int checks;
    int errors;

    // Reference model state per slave instance
    logic [7:0] mdl_mem [3][16];
    logic [2:0] mdl_err [3];
    int         mdl_wait [3];

    apb_slave_regfile #(.WAIT_STATES(1)) dut_w1 (
        .pclk(pclk), .preset(preset), .psel(psel_v[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]),
        .pready(pready_v[0]), .pslverr(pslverr_v[0]), .err(err_v[0])
    );

    apb_slave_regfile #(.WAIT_STATES(0)) dut_w0 (
        .pclk(pclk), .preset(preset), .psel(psel_v[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]),
        .pready(pready_v[1]), .pslverr(pslverr_v[1]), .err(err_v[1])
    );

    apb_slave_regfile #(.WAIT_STATES(7)) dut_w7 (
        .pclk(pclk), .preset(preset), .psel(psel_v[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]),
        .pready(pready_v[2]), .pslverr(pslverr_v[2]), .err(err_v[2])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int a = 0; a < 16; a++) mdl_mem[d][a] = 8'h00;
            mdl_err[d] = 3'b000;
        end
    endtask

    task automatic model_xfer(input int dev, input bit wr, input logic [3:0] addr,
                              input logic [7:0] data, output logic [7:0] exp_rd,
                              output logic exp_se);
        bit a_e;
        bit v_e;
        bit d_e;
        a_e = (int'(addr) >= 12);
        v_e = wr && (addr == 4'd0);
        d_e = wr && (data > 8'hF0);
        if (addr == 4'd0)  exp_rd = 8'hA5;
        else if (a_e)      exp_rd = 8'h00;
        else               exp_rd = mdl_mem[dev][addr];
        exp_se = a_e | v_e | d_e;
        mdl_err[dev] = {a_e, v_e, d_e};
        if (wr && !exp_se) mdl_mem[dev][addr] = data;
    endtask

    // Drives one complete transfer starting just after a rising edge and returns
    // just after the completion edge, so another transfer may follow at once.
    task automatic xfer(input int dev, input bit wr, input logic [3:0] addr,
                        input logic [7:0] data, output int cyc,
                        output logic [7:0] rd, output logic se);
        bit done;
        psel_v      = 3'b000;
        psel_v[dev] = 1'b1;
        penable     = 1'b0;
        pwrite      = wr;
        paddr       = addr;
        pwdata      = data;
        rd          = 8'hxx;
        se          = 1'bx;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc     = 1;
        done    = 1'b0;
        while (!done) begin
            @(negedge pclk);
            if (pready_v[dev] === 1'b1) begin
                rd   = prdata_v[dev];
                se   = pslverr_v[dev];
                done = 1'b1;
            end else begin
                cyc++;
                if (cyc > 20) done = 1'b1;
            end
            @(posedge pclk); #1;
        end
        psel_v  = 3'b000;
        penable = 1'b0;
    endtask

    task automatic test_reset();
        preset  = 1'b1;
        psel_v  = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 4'd0;
        pwdata  = 8'd0;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;
        model_reset();
        @(negedge pclk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (pready_v[d] !== 1'b0 || pslverr_v[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_resp dev%0d pready=%b pslverr=%b expected 0/0",
                         d, pready_v[d], pslverr_v[d]);
            end
            checks++;
            if (prdata_v[d] !== 8'h00 || err_v[d] !== 3'b000) begin
                errors++;
                $display("[TB] FAIL reset_regs dev%0d prdata=%h err=%b expected 00/000",
                         d, prdata_v[d], err_v[d]);
            end
        end
        @(posedge pclk); #1;
    endtask

    // Runs one modelled transfer on a slave and checks every visible result.
    task automatic test_one(input string name, input int dev, input bit wr,
                            input logic [3:0] addr, input logic [7:0] data);
        int         cyc;
        logic [7:0] rd, exp_rd;
        logic       se, exp_se;
        model_xfer(dev, wr, addr, data, exp_rd, exp_se);
        xfer(dev, wr, addr, data, cyc, rd, se);
        checks++;
        if (cyc !== mdl_wait[dev] + 1) begin
            errors++;
            $display("[TB] FAIL %s_ready_cycle got T%0d expected T%0d", name, cyc, mdl_wait[dev] + 1);
        end
        checks++;
        if (se !== exp_se) begin
            errors++;
            $display("[TB] FAIL %s_pslverr got %b expected %b", name, se, exp_se);
        end
        if (!wr) begin
            checks++;
            if (rd !== exp_rd) begin
                errors++;
                $display("[TB] FAIL %s_prdata got %h expected %h", name, rd, exp_rd);
            end
        end
        checks++;
        if (err_v[dev] !== mdl_err[dev]) begin
            errors++;
            $display("[TB] FAIL %s_err got %b expected %b", name, err_v[dev], mdl_err[dev]);
        end
    endtask

    task automatic test_basic_rw();
        test_one("wr5", 0, 1'b1, 4'd5, 8'h3C);
        test_one("rd5", 0, 1'b0, 4'd5, 8'h00);
    endtask

    task automatic test_id_register();
        test_one("rd_id", 0, 1'b0, 4'd0, 8'h00);
        test_one("wr_id", 0, 1'b1, 4'd0, 8'h11);
        test_one("rd_id_again", 0, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic test_addr_range();
        test_one("wr13", 0, 1'b1, 4'd13, 8'h22);
        test_one("rd13", 0, 1'b0, 4'd13, 8'h00);
        test_one("wr11_edge", 0, 1'b1, 4'd11, 8'h6B);
        test_one("rd11_edge", 0, 1'b0, 4'd11, 8'h00);
        test_one("wr12_edge", 0, 1'b1, 4'd12, 8'h01);
    endtask

    task automatic test_data_range();
        test_one("wr3_F5", 0, 1'b1, 4'd3, 8'hF5);
        test_one("rd3_keep", 0, 1'b0, 4'd3, 8'h00);
        test_one("wr3_F0", 0, 1'b1, 4'd3, 8'hF0);
        test_one("rd3_F0", 0, 1'b0, 4'd3, 8'h00);
        test_one("wr4_multi", 0, 1'b1, 4'd14, 8'hFF);
    endtask

    task automatic test_abort();
        logic [2:0] err_before;
        err_before = err_v[0];
        psel_v  = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 4'd6;
        pwdata  = 8'h77;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        checks++;
        if (pready_v[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_wait_pready got %b expected 0", pready_v[0]);
        end
        #1 psel_v = 3'b000;
        @(posedge pclk); #1;
        penable = 1'b0;
        @(negedge pclk);
        checks++;
        if (pready_v[0] !== 1'b0 || err_v[0] !== err_before) begin
            errors++;
            $display("[TB] FAIL abort_state pready=%b err=%b expected 0/%b",
                     pready_v[0], err_v[0], err_before);
        end
        @(posedge pclk); #1;
        test_one("rd6_after_abort", 0, 1'b0, 4'd6, 8'h00);

        // Access strobe with no preceding setup phase
        psel_v  = 3'b001;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            checks++;
            if (pready_v[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL no_setup_pready cycle%0d got %b expected 0", i, pready_v[0]);
            end
        end
        @(posedge pclk); #1;
        psel_v  = 3'b000;
        penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_back_to_back();
        test_one("b2b_wr7", 0, 1'b1, 4'd7, 8'h42);
        test_one("b2b_rd7", 0, 1'b0, 4'd7, 8'h00);
        test_one("b2b_wr7b", 0, 1'b1, 4'd7, 8'h9E);
        test_one("b2b_rd7b", 0, 1'b0, 4'd7, 8'h00);
    endtask

    task automatic test_reset_mid_transfer();
        psel_v  = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 4'd5;
        @(posedge pclk); #1;
        penable = 1'b1;
        preset  = 1'b1;
        @(posedge pclk); #1;
        preset  = 1'b0;
        psel_v  = 3'b000;
        penable = 1'b0;
        model_reset();
        @(negedge pclk);
        checks++;
        if (prdata_v[0] !== 8'h00 || err_v[0] !== 3'b000 || pready_v[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid prdata=%h err=%b pready=%b expected 00/000/0",
                     prdata_v[0], err_v[0], pready_v[0]);
        end
        @(posedge pclk); #1;
        test_one("rd5_after_reset", 0, 1'b0, 4'd5, 8'h00);
    endtask

    task automatic test_wait_variants();
        test_one("w0_wr9", 1, 1'b1, 4'd9, 8'h5A);
        test_one("w0_rd9", 1, 1'b0, 4'd9, 8'h00);
        test_one("w0_wr_bad", 1, 1'b1, 4'd2, 8'hF1);
        test_one("w7_wr2", 2, 1'b1, 4'd2, 8'h4B);
        test_one("w7_rd2", 2, 1'b0, 4'd2, 8'h00);
        test_one("w7_rd15", 2, 1'b0, 4'd15, 8'h00);
    endtask

    task automatic test_random();
        bit         wr;
        logic [3:0] addr;
        logic [7:0] data;
        int         dev;
        for (int i = 0; i < 80; i++) begin
            dev  = (i % 5 == 4) ? int'($urandom_range(1, 2)) : 0;
            wr   = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 15));
            data = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255))
                                               : 8'($urandom_range(0, 255));
            test_one("rand", dev, wr, addr, data);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        mdl_wait[0] = 1;
        mdl_wait[1] = 0;
        mdl_wait[2] = 7;
        model_reset();
        test_reset();
        test_basic_rw();
        test_id_register();
        test_addr_range();
        test_data_range();
        test_abort();
        test_back_to_back();
        test_reset_mid_transfer();
        test_wait_variants();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
